fifo_word_packer: RTL and testbench
===================================

// Module: fifo_word_packer
// PURPOSE
//  Drain stage directly downstream of the synchronous FIFO. Pops IN_WIDTH-bit entries via the
//  FIFO read port (rd_en/empty/rd_data) and packs LANES entries into one wide word. Presents
//  each word on a valid/ready stream with per-lane keep and a last flag. A flush request closes
//  a partial word once the FIFO is empty.
// PARAMETERS
//  IN_WIDTH  8  width of one FIFO entry (one lane)
//  LANES     4  entries per output word (>=2); OUT_WIDTH = IN_WIDTH*LANES
// PORTS
//  clk           in   1          rising-edge clock, the single clock domain
//  rst           in   1          asynchronous reset, active-high
//  fifo_empty    in   1          FIFO empty flag
//  fifo_rd_en    out  1          FIFO pop request
//  fifo_rd_data  in   IN_WIDTH   FIFO read data, valid the cycle after the pop edge
//  flush         in   1          1-cycle pulse: close the current packet once the FIFO drains
//  m_valid       out  1          output word valid
//  m_ready       in   1          downstream accept
//  m_data        out  OUT_WIDTH  packed word; first-popped entry in lane 0 = bits [IN_WIDTH-1:0]
//  m_keep        out  LANES      lane i holds valid data
//  m_last        out  1          word ends a flushed packet
//  busy          out  1          lane_cnt!=0 | rd_pend | m_valid | flush_req
// BEHAVIOUR
//  - Reset (async, immediate) clears all outputs and all state to 0: fifo_rd_en, m_valid,
//    m_data, m_keep, m_last, busy, lane_cnt, rd_pend, flush_req. Entries already popped from
//    the FIFO are discarded. The FIFO is reset separately.
//  - State: pack register plus lane_cnt (0..LANES); rd_pend (a pop was issued last cycle);
//    output register (m_*); flush_req (sticky, set by flush).
//  - FIFO read: the FIFO has 1-cycle read latency. When rd_pend=1, fifo_rd_data is written into
//    pack lane lane_cnt at the edge, and lane_cnt increments.
//  - xfer (pack -> output register) occurs at an edge when (!m_valid | m_ready) and either:
//    * lane_cnt==LANES (full word), or
//    * flush_req & fifo_empty & !rd_pend & lane_cnt!=0 (partial word).
//    On xfer, m_data takes the pack contents, with unused lanes zeroed.
//    m_keep = (1<<lane_cnt)-1. m_last = flush_req & fifo_empty & !rd_pend.
//    lane_cnt returns to 0. flush_req clears if m_last is set.
//  - fifo_rd_en (combinational) = !fifo_empty & !rst & ((lane_cnt+rd_pend < LANES) | xfer).
//    It is never asserted while fifo_empty.
//  - A flush seen with lane_cnt==0, !rd_pend and fifo_empty clears flush_req and emits no word.
//    A flush arriving while flush_req is already set has no extra effect.
//  - Output handshake: a word transfers when m_valid & m_ready. m_data, m_keep and m_last are
//    stable while m_valid & !m_ready. m_valid drops after the accept edge unless a new xfer
//    occurs in the same cycle.
//  - Latency: first pop sampled at edge E -> m_valid rises after edge E+LANES+1.
//    Sustained throughput is 1 word per LANES+1 cycles.
//  - Backpressure: with the output register held, the pack register fills to LANES and pops
//    stop. At most 2*LANES entries are held in the block.
//  - Order is preserved; no entry is lost or duplicated.
// TESTING (IN_WIDTH=8, LANES=4)
//  1. Hold rst=1 -> fifo_rd_en, m_valid, m_keep, m_last, busy all 0. Deassert rst with the
//     FIFO empty -> still all 0.
//  2. FIFO preloaded with 0x00..0x07, m_ready=1 -> words 0x03020100 then 0x07060504, keep 4'hF,
//     last 0. Pops at E..E+3 and E+5..E+8. First m_valid after E+5.
//  3. 12 entries, m_ready=0 -> 8 pops then fifo_rd_en stays 0 and word 0x03020100 is held
//     stable. Raise m_ready -> three words in order, no loss or duplication.
//  4. Push 0xA1,0xA2,0xA3 then pulse flush -> one word 0x00A3A2A1, keep 4'b0111, last 1.
//     busy returns to 0 after the accept.
//  5. Flush with the block idle -> no m_valid, busy high 1 cycle then 0.
//     Push 4 entries then flush -> keep 4'hF, last 1.
//  6. Assert rst while m_valid=1, m_ready=0 -> outputs 0 without waiting for a clock edge.
//     After release, new data 0x10..0x13 -> word 0x13121110.

Source files
------------

// File: rtl/fifo_word_packer.sv
// Drains a 1-cycle-latency FIFO read port and packs LANES entries per output word.
// Output is a registered valid/ready stream with per-lane keep and a flush-driven last flag.
module fifo_word_packer #(
    parameter int IN_WIDTH = 8,
    parameter int LANES    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      fifo_empty,
    output logic                      fifo_rd_en,
    input  logic [IN_WIDTH-1:0]       fifo_rd_data,
    input  logic                      flush,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [IN_WIDTH*LANES-1:0] m_data,
    output logic [LANES-1:0]          m_keep,
    output logic                      m_last,
    output logic                      busy
);

    localparam int OUT_WIDTH = IN_WIDTH * LANES;
    localparam int CW        = $clog2(LANES + 1);

    logic [IN_WIDTH-1:0]  pack [LANES];
    logic [CW-1:0]        lane_cnt;
    logic                 rd_pend;
    logic                 flush_req;

    logic                 drain_done;
    logic                 out_free;
    logic                 full_word;
    logic                 xfer;
    logic [CW:0]          occupancy;
    logic                 room;
    logic [CW-1:0]        wr_base;
    logic [OUT_WIDTH-1:0] pack_word;
    logic [LANES-1:0]     pack_keep;

    // FIFO has no more to give and nothing is in flight: the packet can be closed.
    assign drain_done = flush_req & fifo_empty & ~rd_pend;
    assign out_free   = ~m_valid | m_ready;
    assign full_word  = (lane_cnt == CW'(LANES));
    assign xfer       = out_free & (full_word | (drain_done & (lane_cnt != '0)));

    // Count the entry still in flight so the pack register never overflows.
    assign occupancy  = {1'b0, lane_cnt} + {{CW{1'b0}}, rd_pend};
    assign room       = (occupancy < (CW + 1)'(LANES));
    assign fifo_rd_en = ~fifo_empty & ~rst & (room | xfer);

    assign busy       = (lane_cnt != '0) | rd_pend | m_valid | flush_req;

    // Lane an arriving entry lands in: a transfer this edge frees the pack register.
    assign wr_base    = xfer ? '0 : lane_cnt;

    // NOTE: every variable gets a default at the top of always_comb so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        pack_word = '0;
        pack_keep = '0;
        for (int i = 0; i < LANES; i++) begin
            if (CW'(i) < lane_cnt) begin
                pack_word[i*IN_WIDTH +: IN_WIDTH] = pack[i];
                pack_keep[i]                      = 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the pack array is small and is cleared with the rest of the state, so
            // nothing from before reset can ever reach m_data.
            for (int i = 0; i < LANES; i++) pack[i] <= '0;
            lane_cnt  <= '0;
            rd_pend   <= 1'b0;
            flush_req <= 1'b0;
            m_valid   <= 1'b0;
            m_data    <= '0;
            m_keep    <= '0;
            m_last    <= 1'b0;
        end else begin
            rd_pend <= fifo_rd_en;

            for (int i = 0; i < LANES; i++) begin
                if (rd_pend && (CW'(i) == wr_base)) pack[i] <= fifo_rd_data;
            end
            lane_cnt <= wr_base + CW'(rd_pend);

            if (xfer) begin
                m_valid <= 1'b1;
                m_data  <= pack_word;
                m_keep  <= pack_keep;
                m_last  <= drain_done;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end

            // Clear once the closing word leaves, or when there was nothing to close.
            if (drain_done && (xfer || (lane_cnt == '0))) flush_req <= 1'b0;
            else if (flush)                               flush_req <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed bench for fifo_word_packer: behavioural FIFO in front, word scoreboard behind.
module tb_fifo_word_packer;

    localparam int IW = 8;
    localparam int L  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic [IW-1:0] fifo_rd_data;
    logic          flush;
    logic          m_valid;
    logic          m_ready;
    logic [IW*L-1:0] m_data;
    logic [L-1:0]  m_keep;
    logic          m_last;
    logic          busy;

    int vectors = 0;
    int errors  = 0;

    fifo_word_packer #(.IN_WIDTH(IW), .LANES(L)) dut (
        .clk         (clk),
        .rst         (rst),
        .fifo_empty  (fifo_empty),
        .fifo_rd_en  (fifo_rd_en),
        .fifo_rd_data(fifo_rd_data),
        .flush       (flush),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_keep      (m_keep),
        .m_last      (m_last),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Behavioural FIFO with 1-cycle read latency.
    logic [IW-1:0] fmem [64];
    int wptr = 0;
    int rptr;
    int cyc = 0;
    int pop_q [$];

    assign fifo_empty = (wptr == rptr);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rptr         <= 0;
            fifo_rd_data <= '0;
        end else if (fifo_rd_en) begin
            fifo_rd_data <= fmem[rptr % 64];
            rptr         <= rptr + 1;
        end
    end

    always @(posedge clk) begin
        if (!rst && fifo_rd_en) pop_q.push_back(cyc);
        cyc <= cyc + 1;
    end

    logic [36:0] sb [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: compare each accepted word against the scoreboard head.
    always @(negedge clk) begin
        if (!rst) begin
            if (fifo_rd_en) check("rd_while_empty", fifo_empty, 0);
            if (m_valid && m_ready) begin
                if (sb.size() == 0) check("unexpected_word", {m_data, m_keep, m_last}, 0);
                else                check("word", {m_data, m_keep, m_last}, sb.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [IW-1:0] b);
        fmem[wptr % 64] = b;
        wptr++;
    endtask

    task automatic expect_word(input logic [31:0] d, input logic [3:0] k, input logic l);
        sb.push_back({d, k, l});
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while ((sb.size() != 0 || busy) && n < budget) begin
            step();
            n++;
        end
        check(tag, (n < budget), 1);
    endtask

    task automatic check_idle(input string tag);
        check(tag, {fifo_rd_en, m_valid, m_keep, m_last, busy, m_data}, 0);
    endtask

    initial begin
        int p0;
        int n;
        int offs [8];
        offs = '{0, 1, 2, 3, 5, 6, 7, 8};

        rst = 1'b1; flush = 1'b0; m_ready = 1'b0;
        #12;
        check_idle("reset_held");
        step();
        rst = 1'b0;
        repeat (3) step();
        check_idle("after_release");

        // Two full words back to back, checking pop schedule and first-word latency.
        m_ready = 1'b1;
        p0 = pop_q.size();
        for (int i = 0; i < 8; i++) push(IW'(i));
        expect_word(32'h03020100, 4'hF, 1'b0);
        expect_word(32'h07060504, 4'hF, 1'b0);
        n = 0;
        while (!m_valid && n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        check("first_valid_edges", n, 6);
        drain("drain_t2", 40);
        check("pops_t2", pop_q.size() - p0, 8);
        if (pop_q.size() - p0 >= 8)
            for (int k = 0; k < 8; k++) check("pop_offset", pop_q[p0 + k] - pop_q[p0], offs[k]);

        // Backpressure: block fills to two words and stops popping.
        m_ready = 1'b0;
        p0 = pop_q.size();
        for (int i = 0; i < 12; i++) push(IW'(8'h20 + i));
        expect_word(32'h23222120, 4'hF, 1'b0);
        expect_word(32'h27262524, 4'hF, 1'b0);
        expect_word(32'h2B2A2928, 4'hF, 1'b0);
        repeat (20) step();
        check("pops_held", pop_q.size() - p0, 8);
        check("rd_en_held", fifo_rd_en, 0);
        check("held_word", {m_valid, m_data}, {1'b1, 32'h23222120});
        repeat (3) step();
        check("held_stable", {m_valid, m_data, m_keep, m_last}, {1'b1, 32'h23222120, 4'hF, 1'b0});
        m_ready = 1'b1;
        drain("drain_t3", 60);
        check("pops_t3", pop_q.size() - p0, 12);

        // Partial word closed by flush.
        for (int i = 1; i <= 3; i++) push(IW'(8'hA0 + i));
        expect_word(32'h00A3A2A1, 4'b0111, 1'b1);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        drain("drain_t4", 40);
        check("busy_t4", busy, 0);

        // Flush while idle: no word, busy for one cycle.
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("idle_flush_busy", {busy, m_valid}, 2'b10);
        step();
        check("idle_flush_done", {busy, m_valid}, 2'b00);
        for (int i = 0; i < 4; i++) push(IW'(8'h40 + i));
        expect_word(32'h43424140, 4'hF, 1'b1);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        drain("drain_t5", 40);

        // Asynchronous reset while a word is held.
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(IW'(8'h50 + i));
        n = 0;
        while (!m_valid && n < 20) begin
            step();
            n++;
        end
        check("t6_valid", m_valid, 1);
        step();
        #2;
        rst  = 1'b1;
        wptr = 0;
        #1;
        check_idle("async_reset");
        step();
        step();
        rst = 1'b0;
        step();
        check_idle("t6_release");
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) push(IW'(8'h10 + i));
        expect_word(32'h13121110, 4'hF, 1'b0);
        drain("drain_t6", 40);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, required completion");
        $fatal(1, "watchdog");
    end

endmodule
